// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: operand geometry and the
// operand-loader frame assembly states.
package mac_pkg;

    localparam int WORD_W = 32;
    localparam int OP_W   = 256;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_FULL = 2'd2
    } ld_state_t;

endpackage

// File: rtl/mac_operand_loader_word_deser.sv
// Word-indexed deserializer: writes one input word into an operand-wide
// register at the given word slot, with a synchronous clear.
module word_deser #(
    parameter int WORD_W = mac_pkg::WORD_W,
    parameter int WORDS  = 8,
    parameter int IDX_W  = $clog2(WORDS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          idx,
    input  logic [WORD_W-1:0]         word,
    output logic [WORDS*WORD_W-1:0]   data
);

    // Operand register: cleared on reset or frame drop, else one word slot per write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
        end else if (clr) begin
            data <= '0;
        end else if (wr_en) begin
            data[idx*WORD_W +: WORD_W] <= word;
        end else begin
            data <= data;
        end
    end

endmodule

// File: rtl/mac_operand_loader.sv
// Assembles A/B operand pairs from a word stream and holds one complete pair
// stable for the MAC while the next pair is being loaded.
module mac_operand_loader #(
    parameter int WORD_W = mac_pkg::WORD_W,
    parameter int OP_W   = mac_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [OP_W-1:0]   op_A,
    output logic [OP_W-1:0]   op_B,
    output logic              op_valid,
    input  logic              op_take,
    output logic              frame_err
);

    import mac_pkg::*;

    localparam int WORDS = OP_W / WORD_W;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    ld_state_t        state_r;
    logic [IDX_W-1:0] idx_r;
    logic             accept_s;
    logic             final_word_s;
    logic             err_s;
    logic             wr_a_s;
    logic             wr_b_s;
    logic             xfer_s;
    logic [OP_W-1:0]  buf_a_s;
    logic [OP_W-1:0]  buf_b_s;

    assign in_ready = (state_r != S_FULL);

    // Word steering and frame checks: in_last must coincide exactly with the final B word.
    always_comb begin
        accept_s     = in_valid && in_ready;
        final_word_s = (state_r == S_B) && (idx_r == LAST_IDX);
        wr_a_s       = 1'b0;
        wr_b_s       = 1'b0;
        err_s        = 1'b0;
        if (accept_s) begin
            if (in_last != final_word_s) begin
                err_s = 1'b1;
            end else if (state_r == S_A) begin
                wr_a_s = 1'b1;
            end else begin
                wr_b_s = 1'b1;
            end
        end else begin
            err_s = 1'b0;
        end
        xfer_s = (state_r == S_FULL) && (!op_valid || op_take);
    end

    word_deser #(.WORD_W(WORD_W), .WORDS(WORDS), .IDX_W(IDX_W)) u_deser_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (err_s),
        .wr_en (wr_a_s),
        .idx   (idx_r),
        .word  (in_data),
        .data  (buf_a_s)
    );

    word_deser #(.WORD_W(WORD_W), .WORDS(WORDS), .IDX_W(IDX_W)) u_deser_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (err_s),
        .wr_en (wr_b_s),
        .idx   (idx_r),
        .word  (in_data),
        .data  (buf_b_s)
    );

    // Frame FSM plus output slot; a transfer may coincide with a take, keeping op_valid high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_A;
            idx_r     <= '0;
            op_A      <= '0;
            op_B      <= '0;
            op_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_s;

            if (xfer_s) begin
                op_A     <= buf_a_s;
                op_B     <= buf_b_s;
                op_valid <= 1'b1;
            end else if (op_take) begin
                op_valid <= 1'b0;
            end else begin
                op_valid <= op_valid;
            end

            if (err_s || xfer_s) begin
                state_r <= S_A;
                idx_r   <= '0;
            end else if (accept_s) begin
                case (state_r)
                    S_A: begin
                        if (idx_r == LAST_IDX) begin
                            state_r <= S_B;
                            idx_r   <= '0;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end
                    S_B: begin
                        if (idx_r == LAST_IDX) begin
                            state_r <= S_FULL;
                            idx_r   <= '0;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end
                    default: begin
                        state_r <= S_A;
                        idx_r   <= '0;
                    end
                endcase
            end else begin
                state_r <= state_r;
                idx_r   <= idx_r;
            end
        end
    end

endmodule

// File: tb/tb_mac_operand_loader.sv
// Self-checking bench for mac_operand_loader: hand sequences for handshake
// corners plus a table of good/malformed frames checked through a scoreboard.
module tb_mac_operand_loader;

    localparam int WORD_W = 32;
    localparam int OP_W   = 256;
    localparam int WORDS  = OP_W / WORD_W;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } pair_t;

    typedef struct {
        int unsigned len;
        bit          last_final;
        int          exp_err;
        bit          deliver;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [WORD_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [OP_W-1:0]   op_A;
    logic [OP_W-1:0]   op_B;
    logic              op_valid;
    logic              op_take = 1'b0;
    logic              frame_err;

    int    total = 0;
    int    bad = 0;
    int    err_cnt = 0;
    pair_t sb_q[$];
    logic [WORD_W-1:0] frame_w [2*WORDS];

    mac_operand_loader #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .op_A      (op_A),
        .op_B      (op_B),
        .op_valid  (op_valid),
        .op_take   (op_take),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [OP_W-1:0] act, input logic [OP_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard pop on every consumer handshake, plus frame_err pulse counting.
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt++;
        if (rst_n && op_valid && op_take) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: handshake with empty scoreboard, op_A=%h", op_A);
            end else begin
                pair_t e;
                e = sb_q.pop_front();
                check("sb_op_A", op_A, e.a);
                check("sb_op_B", op_B, e.b);
            end
        end
    end

    function automatic pair_t pack_frame();
        pair_t p;
        for (int i = 0; i < WORDS; i++) begin
            p.a[i*WORD_W +: WORD_W] = frame_w[i];
            p.b[i*WORD_W +: WORD_W] = frame_w[i+WORDS];
        end
        return p;
    endfunction

    task automatic rand_frame();
        for (int i = 0; i < 2*WORDS; i++) frame_w[i] = $urandom;
    endtask

    task automatic put_word(input logic [WORD_W-1:0] d, input logic l);
        int n;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends the first len words; in_last is driven on the final sent word only.
    task automatic send_frame(input int unsigned len, input bit last_final);
        for (int unsigned i = 0; i < len; i++) begin
            put_word(frame_w[i], (i == len - 1) ? last_final : 1'b0);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_take();
        op_take = 1'b1;
        tick(1);
        op_take = 1'b0;
    endtask

    pair_t f1, f2, f3, fr;
    vec_t  vecs[7];
    int    e0;
    logic [OP_W-1:0] exp_a1;
    logic [OP_W-1:0] exp_b1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_a1 = 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
        exp_b1 = 256'h00000018_00000017_00000016_00000015_00000014_00000013_00000012_00000011;

        // Reset values
        rst_n = 1'b0;
        tick(2);
        check("rst_op_A", op_A, '0);
        check("rst_op_B", op_B, '0);
        check("rst_op_valid", op_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick(1);

        // Single frame, no take: 2-cycle latency from final word to op_valid
        for (int i = 0; i < WORDS; i++) begin
            frame_w[i]       = 32'(i + 1);
            frame_w[i+WORDS] = 32'(i + 17);
        end
        f1 = pack_frame();
        sb_q.push_back(f1);
        send_frame(2*WORDS, 1'b1);
        check("lat_valid_n", op_valid, 0);
        check("lat_ready_n", in_ready, 0);
        tick(1);
        check("lat_valid_n1", op_valid, 1);
        check("lat_ready_n1", in_ready, 1);
        check("single_op_A", op_A, exp_a1);
        check("single_op_B", op_B, exp_b1);

        // Backpressure: second frame waits in assembly while frame 1 is held
        rand_frame();
        f2 = pack_frame();
        sb_q.push_back(f2);
        send_frame(2*WORDS, 1'b1);
        tick(3);
        check("bp_in_ready", in_ready, 0);
        check("bp_hold_A", op_A, f1.a);
        check("bp_hold_B", op_B, f1.b);
        pulse_take();
        check("bp_new_A", op_A, f2.a);
        check("bp_new_B", op_B, f2.b);
        check("bp_valid", op_valid, 1);
        check("bp_ready", in_ready, 1);

        // Take lands on the transfer edge: no bubble
        rand_frame();
        f3 = pack_frame();
        sb_q.push_back(f3);
        send_frame(2*WORDS, 1'b1);
        pulse_take();
        check("same_valid", op_valid, 1);
        check("same_op_A", op_A, f3.a);
        check("same_op_B", op_B, f3.b);

        // Missing last while slot is occupied: dropped, slot untouched
        e0 = err_cnt;
        rand_frame();
        send_frame(2*WORDS, 1'b0);
        tick(3);
        check("miss_err", 32'(err_cnt - e0), 1);
        check("miss_hold_A", op_A, f3.a);
        check("miss_valid", op_valid, 1);
        check("miss_ready", in_ready, 1);
        pulse_take();
        check("take_clears_valid", op_valid, 0);

        // Table of frames with a free-running consumer
        vecs[0] = '{len: 16, last_final: 1'b1, exp_err: 0, deliver: 1'b1};
        vecs[1] = '{len: 5,  last_final: 1'b1, exp_err: 1, deliver: 1'b0};
        vecs[2] = '{len: 16, last_final: 1'b1, exp_err: 0, deliver: 1'b1};
        vecs[3] = '{len: 16, last_final: 1'b0, exp_err: 1, deliver: 1'b0};
        vecs[4] = '{len: 9,  last_final: 1'b1, exp_err: 1, deliver: 1'b0};
        vecs[5] = '{len: 1,  last_final: 1'b1, exp_err: 1, deliver: 1'b0};
        vecs[6] = '{len: 16, last_final: 1'b1, exp_err: 0, deliver: 1'b1};
        op_take = 1'b1;
        for (int v = 0; v < 7; v++) begin
            e0 = err_cnt;
            rand_frame();
            if (vecs[v].deliver) sb_q.push_back(pack_frame());
            send_frame(vecs[v].len, vecs[v].last_final);
            tick(4);
            check($sformatf("vec%0d_err", v), 32'(err_cnt - e0), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d_drained", v), 32'(sb_q.size()), 0);
        end
        op_take = 1'b0;

        // Reset mid-frame: partial data discarded without frame_err
        e0 = err_cnt;
        rand_frame();
        send_frame(10, 1'b0);
        rst_n = 1'b0;
        tick(1);
        check("mrst_op_A", op_A, '0);
        check("mrst_op_B", op_B, '0);
        check("mrst_valid", op_valid, 0);
        check("mrst_ready", in_ready, 1);
        rst_n = 1'b1;
        tick(2);
        check("mrst_no_err", 32'(err_cnt - e0), 0);
        rand_frame();
        fr = pack_frame();
        sb_q.push_back(fr);
        send_frame(2*WORDS, 1'b1);
        tick(1);
        check("mrst_fresh_A", op_A, fr.a);
        check("mrst_fresh_B", op_B, fr.b);
        pulse_take();
        tick(2);
        check("final_sb_empty", 32'(sb_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
